hsid_job_sequencer: RTL and testbench

- Top-level controller that runs the HSI identification core over a batch of captured pixels, one core run per pixel, under software control.
- Latches the batch configuration, then for each pixel issues a single-cycle start to the core and waits for its done pulse.
- Captures the best-match reference index and its MSE, and emits them on a valid/ready result stream.
- Raises a completion interrupt at end of batch and supervises each run with a watchdog timeout and software abort.

---
 rtl/hsid_pkg.sv | 17 +
 rtl/hsid_watchdog.sv | 30 +++
 rtl/hsid_job_sequencer.sv | 150 +++++++++++++++
 tb/tb_hsid_job_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsid_pkg.sv
// hsid_pkg: shared widths and the job sequencer state type for the HSI identification block.
// No ports; imported by hsid_watchdog and hsid_job_sequencer.
package hsid_pkg;
   localparam int HSID_HSP_BANDS_WIDTH   = 6;
   localparam int HSID_HSP_LIBRARY_WIDTH = 8;
   localparam int HSID_MSE_WIDTH         = 24;
   localparam int HSID_SEQ_TIMEOUT_WIDTH = 20;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE,
      EMIT,
      FINISH,
      KILL
   } hsid_seq_state_t;
endpackage

// File: rtl/hsid_watchdog.sv
// hsid_watchdog: run-supervision counter for the job sequencer.
// Ports: clk, rst_n (async active-low), clr (zero the count, wins over en),
//        en (count one per cycle), expired (count reaches 2**WIDTH-1 on this edge).
module hsid_watchdog
   import hsid_pkg::*;
#(
   parameter int WIDTH = HSID_SEQ_TIMEOUT_WIDTH
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [WIDTH-1:0] LAST = {{(WIDTH-1){1'b1}}, 1'b0};

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;

   // Flags the cycle whose increment would land on the limit, so the run is
   // cut after exactly 2**WIDTH-1 supervised cycles.
   assign expired = en && !clr && (cnt == LAST);
endmodule

// File: rtl/hsid_job_sequencer.sv
// hsid_job_sequencer: runs the HSI identification core once per pixel of a batch and
// streams the best-match reference/MSE of each pixel on a valid/ready interface.
// Ports: clk, rst_n (async active-low);
//        cfg_start/cfg_abort pulses and cfg_num_pixels/cfg_library_size/cfg_band_threshold;
//        core_library_size/core_band_threshold (latched batch config), core_start/core_clear pulses,
//        core_idle/core_done/core_min_ref/core_min_mse from the core;
//        res_valid/res_ready/res_pixel_idx/res_ref_idx/res_mse result stream;
//        busy, irq (one-cycle end-of-batch pulse), err_timeout/err_abort (sticky until next start).
module hsid_job_sequencer
   import hsid_pkg::*;
#(
   parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
   parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
   parameter int MSE_WIDTH         = HSID_MSE_WIDTH,
   parameter int PIXEL_WIDTH       = 16,
   parameter int TIMEOUT_WIDTH     = HSID_SEQ_TIMEOUT_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_start,
   input  logic                         cfg_abort,
   input  logic [PIXEL_WIDTH-1:0]       cfg_num_pixels,
   input  logic [HSP_LIBRARY_WIDTH-1:0] cfg_library_size,
   input  logic [HSP_BANDS_WIDTH-1:0]   cfg_band_threshold,
   output logic [HSP_LIBRARY_WIDTH-1:0] core_library_size,
   output logic [HSP_BANDS_WIDTH-1:0]   core_band_threshold,
   output logic                         core_start,
   output logic                         core_clear,
   input  logic                         core_idle,
   input  logic                         core_done,
   input  logic [HSP_LIBRARY_WIDTH-1:0] core_min_ref,
   input  logic [MSE_WIDTH-1:0]         core_min_mse,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [PIXEL_WIDTH-1:0]       res_pixel_idx,
   output logic [HSP_LIBRARY_WIDTH-1:0] res_ref_idx,
   output logic [MSE_WIDTH-1:0]         res_mse,
   output logic                         busy,
   output logic                         irq,
   output logic                         err_timeout,
   output logic                         err_abort
);
   hsid_seq_state_t        state;
   logic [PIXEL_WIDTH-1:0] num_pixels;
   logic [PIXEL_WIDTH-1:0] pixel_idx;
   logic                   launch;
   logic                   wd_en;
   logic                   wd_clr;
   logic                   wd_expired;
   logic                   abort_hit;
   logic                   timeout_hit;

   assign launch      = (state == LAUNCH) && core_idle;
   assign wd_en       = (state == LAUNCH) || (state == WAIT_DONE);
   // The count restarts on every core_start and idles at zero outside LAUNCH/WAIT_DONE.
   assign wd_clr      = launch || !wd_en;
   assign abort_hit   = cfg_abort && (state != IDLE) && (state != KILL);
   // A done arriving on the expiry cycle still counts as a completed run.
   assign timeout_hit = wd_expired && !((state == WAIT_DONE) && core_done);

   hsid_watchdog #(.WIDTH(TIMEOUT_WIDTH)) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state               <= IDLE;
         num_pixels          <= '0;
         pixel_idx           <= '0;
         core_library_size   <= '0;
         core_band_threshold <= '0;
         core_start          <= 1'b0;
         core_clear          <= 1'b0;
         res_valid           <= 1'b0;
         res_pixel_idx       <= '0;
         res_ref_idx         <= '0;
         res_mse             <= '0;
         busy                <= 1'b0;
         irq                 <= 1'b0;
         err_timeout         <= 1'b0;
         err_abort           <= 1'b0;
      end else begin
         core_start <= 1'b0;
         core_clear <= 1'b0;
         irq        <= 1'b0;
         if (abort_hit || timeout_hit) begin
            // Abort outranks both a same-cycle done and the watchdog.
            if (abort_hit)
               err_abort <= 1'b1;
            else
               err_timeout <= 1'b1;
            core_clear <= 1'b1;
            irq        <= 1'b1;
            res_valid  <= 1'b0;
            state      <= KILL;
         end else
            case (state)
               IDLE:
                  if (cfg_start) begin
                     err_timeout <= 1'b0;
                     err_abort   <= 1'b0;
                     if (cfg_num_pixels != '0) begin
                        num_pixels          <= cfg_num_pixels;
                        core_library_size   <= cfg_library_size;
                        core_band_threshold <= cfg_band_threshold;
                        pixel_idx           <= '0;
                        busy                <= 1'b1;
                        state               <= LAUNCH;
                     end else
                        irq <= 1'b1;
                  end
               LAUNCH:
                  if (launch) begin
                     core_start <= 1'b1;
                     state      <= WAIT_DONE;
                  end
               WAIT_DONE:
                  if (core_done) begin
                     res_pixel_idx <= pixel_idx;
                     res_ref_idx   <= core_min_ref;
                     res_mse       <= core_min_mse;
                     res_valid     <= 1'b1;
                     state         <= EMIT;
                  end
               EMIT:
                  if (res_ready) begin
                     res_valid <= 1'b0;
                     if (pixel_idx == num_pixels - 1'b1) begin
                        irq   <= 1'b1;
                        state <= FINISH;
                     end else begin
                        pixel_idx <= pixel_idx + 1'b1;
                        state     <= LAUNCH;
                     end
                  end
               FINISH, KILL: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
      end
endmodule

// File: tb/tb_hsid_job_sequencer.sv
// tb_hsid_job_sequencer: directed self-checking bench for hsid_job_sequencer with a behavioural core.
module tb_hsid_job_sequencer;
   import hsid_pkg::*;

   localparam int LW = HSID_HSP_LIBRARY_WIDTH;
   localparam int BW = HSID_HSP_BANDS_WIDTH;
   localparam int MW = HSID_MSE_WIDTH;
   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_start = 1'b0, cfg_abort = 1'b0, wd_start = 1'b0;
   logic [PW-1:0] cfg_num_pixels = '0;
   logic [LW-1:0] cfg_library_size = '0;
   logic [BW-1:0] cfg_band_threshold = '0;
   logic [LW-1:0] core_library_size, core_min_ref = '0, res_ref_idx;
   logic [BW-1:0] core_band_threshold;
   logic          core_start, core_clear, core_idle, core_done = 1'b0;
   logic [MW-1:0] core_min_mse = '0, res_mse;
   logic          res_valid, res_ready = 1'b1, busy, irq, err_timeout, err_abort;
   logic [PW-1:0] res_pixel_idx;

   logic          wd_abort = 1'b0, wd_core_idle = 1'b1, wd_core_done = 1'b0;
   logic [LW-1:0] wd_library_size, wd_res_ref_idx;
   logic [BW-1:0] wd_band_threshold;
   logic          wd_core_start, wd_core_clear, wd_res_valid, wd_busy, wd_irq, wd_err_timeout, wd_err_abort;
   logic [MW-1:0] wd_res_mse;
   logic [PW-1:0] wd_res_pixel_idx;

   int checks = 0, errors = 0, cyc = 0, lat = 10, cnt = 0, resp = 0;
   logic running = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hsid_job_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .cfg_num_pixels(cfg_num_pixels), .cfg_library_size(cfg_library_size),
      .cfg_band_threshold(cfg_band_threshold), .core_library_size(core_library_size),
      .core_band_threshold(core_band_threshold), .core_start(core_start), .core_clear(core_clear),
      .core_idle(core_idle), .core_done(core_done), .core_min_ref(core_min_ref),
      .core_min_mse(core_min_mse), .res_valid(res_valid), .res_ready(res_ready),
      .res_pixel_idx(res_pixel_idx), .res_ref_idx(res_ref_idx), .res_mse(res_mse),
      .busy(busy), .irq(irq), .err_timeout(err_timeout), .err_abort(err_abort)
   );

   hsid_job_sequencer #(.TIMEOUT_WIDTH(4)) dut_wd (
      .clk(clk), .rst_n(rst_n), .cfg_start(wd_start), .cfg_abort(wd_abort),
      .cfg_num_pixels(cfg_num_pixels), .cfg_library_size(cfg_library_size),
      .cfg_band_threshold(cfg_band_threshold), .core_library_size(wd_library_size),
      .core_band_threshold(wd_band_threshold), .core_start(wd_core_start), .core_clear(wd_core_clear),
      .core_idle(wd_core_idle), .core_done(wd_core_done), .core_min_ref(core_min_ref),
      .core_min_mse(core_min_mse), .res_valid(wd_res_valid), .res_ready(res_ready),
      .res_pixel_idx(wd_res_pixel_idx), .res_ref_idx(wd_res_ref_idx), .res_mse(wd_res_mse),
      .busy(wd_busy), .irq(wd_irq), .err_timeout(wd_err_timeout), .err_abort(wd_err_abort)
   );

   function automatic logic [LW-1:0] ref_of(int i);
      return (i % 3 == 0) ? 8'd2 : (i % 3 == 1) ? 8'd5 : 8'd7;
   endfunction

   function automatic logic [MW-1:0] mse_of(int i);
      return 24'(1000 * (i + 1) + 37);
   endfunction

   // Core model: done pulse lat cycles after core_start, answers from a fixed table.
   assign core_idle = !running;
   always @(posedge clk) begin
      core_done <= 1'b0;
      if (!rst_n || core_clear) begin
         running <= 1'b0;
         if (!rst_n) resp <= 0;
      end else if (core_start) begin
         running <= 1'b1;
         cnt     <= lat;
      end else if (running) begin
         cnt <= cnt - 1;
         if (cnt == 1) begin
            running      <= 1'b0;
            core_done    <= 1'b1;
            core_min_ref <= ref_of(resp);
            core_min_mse <= mse_of(resp);
            resp         <= resp + 1;
         end
      end
   end

   task automatic do_reset;
      rst_n = 1'b0;
      cfg_start = 1'b0; cfg_abort = 1'b0; wd_start = 1'b0; res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      checks++;
      if ({busy, irq, core_start, core_clear, res_valid, err_timeout, err_abort} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000000", {busy, irq, core_start, core_clear, res_valid, err_timeout, err_abort});
      end
      checks++;
      if (core_library_size !== '0 || core_band_threshold !== '0 || res_pixel_idx !== '0 || res_mse !== '0) begin
         errors++;
         $display("FAIL reset_regs: lib=%0d band=%0d pix=%0d mse=%0d expected all 0", core_library_size, core_band_threshold, res_pixel_idx, res_mse);
      end
   endtask

   task automatic test_batch;
      int n = 0, irqs = 0, starts = 0, t_done = -1, t_start2 = -1;
      logic cfg_ok = 1'b1;
      do_reset;
      lat = 50;
      cfg_num_pixels = 3; cfg_library_size = 20; cfg_band_threshold = 9;
      pulse_start;
      cfg_num_pixels = 7; cfg_library_size = 99; cfg_band_threshold = 1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL batch_busy: got %b expected 1", busy); end
      for (int i = 0; i < 400 && busy; i++) begin
         if (core_start) begin starts++; if (starts == 2) t_start2 = cyc; end
         if (core_done && t_done < 0) t_done = cyc;
         if (irq) irqs++;
         if (core_library_size !== 20 || core_band_threshold !== 9) cfg_ok = 1'b0;
         if (res_valid) begin
            checks++;
            if (res_pixel_idx !== n || res_ref_idx !== ref_of(n) || res_mse !== mse_of(n)) begin
               errors++;
               $display("FAIL batch_result%0d: pix=%0d ref=%0d mse=%0d expected pix=%0d ref=%0d mse=%0d",
                        n, res_pixel_idx, res_ref_idx, res_mse, n, ref_of(n), mse_of(n));
            end
            n++;
         end
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL batch_end: busy=%b expected 0 within 400 cycles", busy); end
      checks++;
      if (n != 3 || starts != 3 || irqs != 1) begin
         errors++;
         $display("FAIL batch_counts: results=%0d starts=%0d irqs=%0d expected 3 3 1", n, starts, irqs);
      end
      checks++;
      if (!cfg_ok) begin errors++; $display("FAIL batch_cfg_stable: core config moved, expected lib=20 band=9"); end
      checks++;
      if (err_timeout !== 1'b0 || err_abort !== 1'b0) begin
         errors++;
         $display("FAIL batch_errs: timeout=%b abort=%b expected 0 0", err_timeout, err_abort);
      end
      checks++;
      if (t_start2 - t_done != 3) begin
         errors++;
         $display("FAIL batch_latency: done-to-next-start=%0d expected 3", t_start2 - t_done);
      end
   endtask

   task automatic test_backpressure;
      logic [PW-1:0] c_pix;
      logic [LW-1:0] c_ref;
      logic [MW-1:0] c_mse;
      logic stable = 1'b1;
      int starts = 0, got = 0;
      do_reset;
      lat = 5; res_ready = 1'b0;
      cfg_num_pixels = 2; cfg_library_size = 4; cfg_band_threshold = 3;
      pulse_start;
      for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
      checks++;
      if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_wait_valid: res_valid=%b expected 1 within 100 cycles", res_valid); end
      c_pix = res_pixel_idx; c_ref = res_ref_idx; c_mse = res_mse;
      repeat (20) begin
         @(negedge clk);
         if (!res_valid || res_pixel_idx !== c_pix || res_ref_idx !== c_ref || res_mse !== c_mse) stable = 1'b0;
         if (core_start) starts++;
      end
      checks++;
      if (!stable || starts != 0) begin
         errors++;
         $display("FAIL bp_hold: stable=%b starts=%0d expected 1 0", stable, starts);
      end
      checks++;
      if (c_pix !== 0 || c_ref !== ref_of(0) || c_mse !== mse_of(0)) begin
         errors++;
         $display("FAIL bp_first: pix=%0d ref=%0d mse=%0d expected 0 %0d %0d", c_pix, c_ref, c_mse, ref_of(0), mse_of(0));
      end
      res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_handshake: res_valid=%b busy=%b expected 0 1", res_valid, busy);
      end
      for (int i = 0; i < 100 && busy; i++) begin
         if (res_valid) begin
            got++;
            checks++;
            if (res_pixel_idx !== 1 || res_ref_idx !== ref_of(1)) begin
               errors++;
               $display("FAIL bp_second: pix=%0d ref=%0d expected 1 %0d", res_pixel_idx, res_ref_idx, ref_of(1));
            end
         end
         @(negedge clk);
      end
      checks++;
      if (got != 1 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain: results=%0d busy=%b expected 1 0", got, busy); end
   endtask

   task automatic test_zero_pixels;
      do_reset;
      cfg_num_pixels = 0;
      pulse_start;
      checks++;
      if (irq !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0) begin
         errors++;
         $display("FAIL zero_irq: irq=%b busy=%b core_start=%b expected 1 0 0", irq, busy, core_start);
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b0 || busy !== 1'b0 || core_start !== 1'b0) begin
         errors++;
         $display("FAIL zero_after: irq=%b busy=%b core_start=%b expected 0 0 0", irq, busy, core_start);
      end
   endtask

   task automatic test_timeout;
      int t_start = -1, t_clear = -1;
      logic irq_ok = 1'b0;
      do_reset;
      cfg_num_pixels = 1; cfg_library_size = 6;
      wd_start = 1'b1;
      @(negedge clk);
      wd_start = 1'b0;
      for (int i = 0; i < 60 && t_clear < 0; i++) begin
         if (wd_core_start && t_start < 0) t_start = cyc;
         if (wd_core_clear) begin
            t_clear = cyc;
            irq_ok = wd_irq && wd_err_timeout && !wd_err_abort && !wd_res_valid;
         end
         @(negedge clk);
      end
      checks++;
      if (t_start < 0 || t_clear < 0 || t_clear - t_start != 15) begin
         errors++;
         $display("FAIL timeout_delay: start=%0d clear=%0d gap=%0d expected gap 15", t_start, t_clear, t_clear - t_start);
      end
      checks++;
      if (!irq_ok) begin errors++; $display("FAIL timeout_flags: irq/err_timeout/err_abort/res_valid wrong at kill, expected 1 1 0 0"); end
      checks++;
      if (wd_busy !== 1'b0 || wd_err_timeout !== 1'b1 || wd_irq !== 1'b0) begin
         errors++;
         $display("FAIL timeout_after: busy=%b err_timeout=%b irq=%b expected 0 1 0", wd_busy, wd_err_timeout, wd_irq);
      end
   endtask

   task automatic test_abort_vs_done;
      do_reset;
      lat = 8;
      cfg_num_pixels = 2;
      pulse_start;
      for (int i = 0; i < 100 && !core_done; i++) @(negedge clk);
      checks++;
      if (core_done !== 1'b1) begin errors++; $display("FAIL abort_wait_done: core_done=%b expected 1 within 100 cycles", core_done); end
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      checks++;
      if ({core_clear, irq, res_valid, err_abort, err_timeout, busy} !== 6'b110101) begin
         errors++;
         $display("FAIL abort_kill: clear,irq,valid,err_abort,err_timeout,busy=%b expected 110101",
                  {core_clear, irq, res_valid, err_abort, err_timeout, busy});
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || irq !== 1'b0 || err_abort !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle: busy=%b valid=%b irq=%b err_abort=%b expected 0 0 0 1", busy, res_valid, irq, err_abort);
      end
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      checks++;
      if (irq !== 1'b0 || core_clear !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_idle: irq=%b clear=%b busy=%b expected 0 0 0", irq, core_clear, busy);
      end
   endtask

   task automatic test_reset_mid;
      int got = 0, irqs = 0;
      do_reset;
      lat = 40;
      cfg_num_pixels = 2; cfg_library_size = 17; cfg_band_threshold = 5;
      pulse_start;
      for (int i = 0; i < 20 && !core_start; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, irq, core_start, core_clear, res_valid, err_timeout, err_abort} !== 7'b0 ||
          core_library_size !== '0 || core_band_threshold !== '0) begin
         errors++;
         $display("FAIL reset_mid_async: flags=%b lib=%0d band=%0d expected 0", {busy, irq, core_start, core_clear, res_valid,
                  err_timeout, err_abort}, core_library_size, core_band_threshold);
      end
      @(negedge clk);
      rst_n = 1'b1;
      lat = 5;
      cfg_num_pixels = 1; cfg_library_size = 33;
      @(negedge clk);
      pulse_start;
      for (int i = 0; i < 100 && busy; i++) begin
         if (irq) irqs++;
         if (res_valid) begin
            got++;
            checks++;
            if (res_pixel_idx !== 0 || res_ref_idx !== ref_of(0) || res_mse !== mse_of(0)) begin
               errors++;
               $display("FAIL reset_mid_rerun: pix=%0d ref=%0d mse=%0d expected 0 %0d %0d", res_pixel_idx, res_ref_idx, res_mse,
                        ref_of(0), mse_of(0));
            end
         end
         @(negedge clk);
      end
      checks++;
      if (got != 1 || irqs != 1 || busy !== 1'b0 || core_library_size !== 33) begin
         errors++;
         $display("FAIL reset_mid_done: results=%0d irqs=%0d busy=%b lib=%0d expected 1 1 0 33", got, irqs, busy, core_library_size);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_batch;
      test_backpressure;
      test_zero_pixels;
      test_timeout;
      test_abort_vs_done;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
